mc_ctrl: RTL and testbench

Multi-cycle sequencing controller for the MIPS datapath. It walks each instruction through fetch, decode, execute, memory and writeback states and drives the datapath enables one state at a time. It handles a request/acknowledge handshake to a shared single-port instruction/data memory, with a wait-state watchdog. It sits beside the datapath in place of the single-cycle decoder and reuses the datapath encodings for ALUOp, NPCOp, GPRSel and WDSel unchanged.

---
 rtl/mc_ctrl_pkg.sv | 70 +++++++
 rtl/mc_decode.sv | 74 +++++++
 rtl/mc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: datapath select
// codes, FSM state codes and the decoded-instruction bundle.
package mc_ctrl_pkg;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_SLLV = 4'd12;
  localparam logic [3:0] ALU_LUI  = 4'd13;

  localparam logic [3:0] NPC_PLUS4  = 4'd0;
  localparam logic [3:0] NPC_BRANCH = 4'd1;
  localparam logic [3:0] NPC_JUMP   = 4'd2;
  localparam logic [3:0] NPC_JR     = 4'd3;
  localparam logic [3:0] NPC_JALR   = 4'd4;

  localparam logic [1:0] GPRSel_RD = 2'b00;
  localparam logic [1:0] GPRSel_RT = 2'b01;
  localparam logic [1:0] GPRSel_31 = 2'b10;

  localparam logic [1:0] WDSel_ALU = 2'b00;
  localparam logic [1:0] WDSel_MEM = 2'b01;
  localparam logic [1:0] WDSel_PC  = 2'b10;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWR  = 4'd5,
    S_WB     = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8
  } state_e;

  typedef enum logic [3:0] {
    CL_NONE = 4'd0,
    CL_R    = 4'd1,
    CL_I    = 4'd2,
    CL_LW   = 4'd3,
    CL_SW   = 4'd4,
    CL_BEQ  = 4'd5,
    CL_BNE  = 4'd6,
    CL_J    = 4'd7,
    CL_JAL  = 4'd8,
    CL_JR   = 4'd9,
    CL_JALR = 4'd10,
    CL_ILL  = 4'd11
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       ext_op;
    logic [1:0] gpr_sel;
    logic [1:0] wd_sel;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational Op/Funct decode into instruction class and
// per-instruction datapath fields; registered by mc_ctrl in DECODE.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec     = '0;
    dec.cls = CL_ILL;
    unique case (op)
      6'h00: begin
        dec.cls     = CL_R;
        dec.gpr_sel = GPRSel_RD;
        dec.wd_sel  = WDSel_ALU;
        unique case (funct)
          6'h20, 6'h21: dec.alu_op = ALU_ADD;
          6'h22, 6'h23: dec.alu_op = ALU_SUB;
          6'h24: dec.alu_op = ALU_AND;
          6'h25: dec.alu_op = ALU_OR;
          6'h26: dec.alu_op = ALU_XOR;
          6'h27: dec.alu_op = ALU_NOR;
          6'h2A: dec.alu_op = ALU_SLT;
          6'h2B: dec.alu_op = ALU_SLTU;
          6'h00: dec.alu_op = ALU_SLL;
          6'h02: dec.alu_op = ALU_SRL;
          6'h03: dec.alu_op = ALU_SRA;
          6'h04: dec.alu_op = ALU_SLLV;
          6'h08: dec.cls = CL_JR;
          6'h09: begin
            dec.cls    = CL_JALR;
            dec.wd_sel = WDSel_PC;
          end
          default: dec.cls = CL_ILL;
        endcase
      end
      6'h08, 6'h0A: begin
        dec.cls     = CL_I;
        dec.alu_op  = (op == 6'h08) ? ALU_ADD : ALU_SLT;
        dec.alu_src = 1'b1;
        dec.ext_op  = 1'b1;
        dec.gpr_sel = GPRSel_RT;
      end
      6'h0C, 6'h0D, 6'h0F: begin
        dec.cls     = CL_I;
        dec.alu_op  = (op == 6'h0C) ? ALU_AND :
                      (op == 6'h0D) ? ALU_OR : ALU_LUI;
        dec.alu_src = 1'b1;
        dec.gpr_sel = GPRSel_RT;
      end
      6'h23, 6'h2B: begin
        dec.cls     = (op == 6'h23) ? CL_LW : CL_SW;
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.ext_op  = 1'b1;
        dec.gpr_sel = GPRSel_RT;
        dec.wd_sel  = WDSel_MEM;
      end
      6'h04: dec.cls = CL_BEQ;
      6'h05: dec.cls = CL_BNE;
      6'h02: dec.cls = CL_J;
      6'h03: begin
        dec.cls     = CL_JAL;
        dec.gpr_sel = GPRSel_31;
        dec.wd_sel  = WDSel_PC;
      end
      default: dec.cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing FSM: fetch/decode/execute/memory/writeback with
// a req/ack memory handshake and a wait-state watchdog.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       ALUSrc,
  output logic       EXTOp,
  output logic [3:0] ALUOp,
  output logic [3:0] NPCOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  localparam int CW = $clog2(WAIT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  state_e        state_q, state_d;
  dec_t          dec_q, dec_d, dec_w;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gap_q, gap_d;
  logic          ill_q, ill_d;
  logic          berr_q, berr_d;
  logic          req_ok, timeout;

  mc_decode u_dec (
    .op    (Op),
    .funct (Funct),
    .dec   (dec_w)
  );

  // gap_q forces one idle request cycle after a watchdog abort
  assign req_ok  = (state_q == S_FETCH || state_q == S_MEMRD ||
                    state_q == S_MEMWR) && !gap_q;
  assign timeout = req_ok && !mem_ack && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    dec_d    = dec_q;
    gap_d    = 1'b0;
    ill_d    = ill_q;
    berr_d   = berr_q;
    cnt_d    = (req_ok && !mem_ack && !timeout) ? cnt_q + 1'b1 : '0;
    mem_req  = req_ok;
    mem_we   = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    EXTOp    = 1'b0;
    ALUOp    = ALU_NOP;
    NPCOp    = NPC_PLUS4;
    GPRSel   = GPRSel_RD;
    WDSel    = WDSel_ALU;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (req_ok && mem_ack) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          berr_d = 1'b1;
          gap_d  = 1'b1;
        end
      end
      S_DECODE: begin
        dec_d = dec_w;
        unique case (dec_w.cls)
          CL_ILL: begin
            PCWrite = 1'b1;
            ill_d   = 1'b1;
            state_d = S_FETCH;
          end
          CL_BEQ, CL_BNE: state_d = S_BRANCH;
          CL_J, CL_JAL, CL_JR, CL_JALR: state_d = S_JUMP;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ALUOp   = dec_q.alu_op;
        ALUSrc  = dec_q.alu_src;
        EXTOp   = dec_q.ext_op;
        state_d = (dec_q.cls == CL_LW) ? S_MEMRD :
                  (dec_q.cls == CL_SW) ? S_MEMWR : S_WB;
      end
      S_MEMRD, S_MEMWR: begin
        IorD   = 1'b1;
        mem_we = req_ok && (state_q == S_MEMWR);
        if (req_ok && mem_ack) begin
          PCWrite = (state_q == S_MEMWR);
          state_d = (state_q == S_MEMWR) ? S_FETCH : S_WB;
        end else if (timeout) begin
          PCWrite = 1'b1;
          berr_d  = 1'b1;
          gap_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        ALUOp    = dec_q.alu_op;
        ALUSrc   = dec_q.alu_src;
        EXTOp    = dec_q.ext_op;
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        GPRSel   = dec_q.gpr_sel;
        WDSel    = dec_q.wd_sel;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUOp   = ALU_SUB;
        EXTOp   = 1'b1;
        PCWrite = 1'b1;
        if ((dec_q.cls == CL_BEQ && Zero) ||
            (dec_q.cls == CL_BNE && !Zero))
          NPCOp = NPC_BRANCH;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        unique case (dec_q.cls)
          CL_JR:   NPCOp = NPC_JR;
          CL_JALR: NPCOp = NPC_JALR;
          default: NPCOp = NPC_JUMP;
        endcase
        RegWrite = (dec_q.cls == CL_JAL) || (dec_q.cls == CL_JALR);
        GPRSel   = dec_q.gpr_sel;
        WDSel    = dec_q.wd_sel;
        state_d  = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_RESET;
      dec_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= 1'b0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end

  assign illegal = ill_q;
  assign bus_err = berr_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed per-cycle vector bench for mc_ctrl (WAIT_MAX=4), plus a
// hand-written mid-MEMWR reset sequence.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [5:0] Op = '0;
  logic [5:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite;
  logic       ALUSrc, EXTOp, illegal, bus_err;
  logic [3:0] ALUOp, NPCOp, state;
  logic [1:0] GPRSel, WDSel;

  mc_ctrl #(.WAIT_MAX(4)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .GPRSel(GPRSel), .WDSel(WDSel), .illegal(illegal), .bus_err(bus_err),
    .state(state)
  );

  always #5 clk = ~clk;

  // state codes
  localparam logic [3:0] RS = 4'd0, FE = 4'd1, DE = 4'd2, EX = 4'd3;
  localparam logic [3:0] MR = 4'd4, MW = 4'd5, WB = 4'd6, BR = 4'd7;
  localparam logic [3:0] JP = 4'd8;
  // strobes: {req, we, iord, irw, pcw, rw}
  localparam logic [5:0] NONE = 6'b000000, FACK = 6'b100100;
  localparam logic [5:0] FREQ = 6'b100000, RDQ = 6'b101000;
  localparam logic [5:0] WRQ = 6'b111000, WRB = 6'b000011;
  localparam logic [5:0] PCW = 6'b000010, WRAB = 6'b111010;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       ack;
    logic [3:0] st;
    logic [5:0] strb;
    logic       sc;
    logic [3:0] npc;
    logic [1:0] gpr;
    logic [1:0] wd;
    logic       ill;
    logic       be;
  } vec_t;

  vec_t vq[$];
  int errors = 0;
  int checks = 0;

  function automatic vec_t v(input logic [5:0] op, fn,
                             input logic z, ack,
                             input logic [3:0] st,
                             input logic [5:0] strb,
                             input logic sc,
                             input logic [3:0] npc,
                             input logic [1:0] gpr, wd,
                             input logic ill, be);
    vec_t r;
    r = '{op, fn, z, ack, st, strb, sc, npc, gpr, wd, ill, be};
    return r;
  endfunction

  task automatic check(input vec_t x, input int idx);
    logic [19:0] got, exp, m;
    got = {state, mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite,
           NPCOp, GPRSel, WDSel, illegal, bus_err};
    exp = {x.st, x.strb, x.npc, x.gpr, x.wd, x.ill, x.be};
    m   = x.sc ? 20'hFFFFF : 20'hFFC03;
    checks++;
    if ((got & m) != (exp & m)) begin
      errors++;
      $display("FAIL vec%0d: got %05h want %05h (mask %05h)",
               idx, got, exp, m);
    end
  endtask

  task automatic apply(input vec_t x, input int idx);
    Op = x.op; Funct = x.fn; Zero = x.z; mem_ack = x.ack;
    #1;
    check(x, idx);
  endtask

  initial begin
    // addu, zero wait
    vq.push_back(v(0, 6'h21, 0, 0, RS, NONE, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 6'h21, 0, 1, FE, FACK, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 6'h21, 0, 0, DE, NONE, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 6'h21, 0, 0, EX, NONE, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 6'h21, 0, 0, WB, WRB, 1, 0, 0, 0, 0, 0));
    // lw, ack in 4th MEMRD cycle (coincides with watchdog limit)
    vq.push_back(v(6'h23, 0, 0, 1, FE, FACK, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h23, 0, 0, 0, DE, NONE, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h23, 0, 0, 0, EX, NONE, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h23, 0, 0, 0, MR, RDQ, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h23, 0, 0, 0, MR, RDQ, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h23, 0, 0, 0, MR, RDQ, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h23, 0, 0, 1, MR, RDQ, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h23, 0, 0, 0, WB, WRB, 1, 0, 1, 1, 0, 0));
    // beq taken, bne not taken
    vq.push_back(v(6'h04, 0, 1, 1, FE, FACK, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h04, 0, 1, 0, DE, NONE, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h04, 0, 1, 0, BR, PCW, 1, 1, 0, 0, 0, 0));
    vq.push_back(v(6'h05, 0, 1, 1, FE, FACK, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h05, 0, 1, 0, DE, NONE, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h05, 0, 1, 0, BR, PCW, 1, 0, 0, 0, 0, 0));
    // jal
    vq.push_back(v(6'h03, 0, 0, 1, FE, FACK, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h03, 0, 0, 0, DE, NONE, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h03, 0, 0, 0, JP, WRB, 1, 2, 2, 2, 0, 0));
    // illegal opcode
    vq.push_back(v(6'h3F, 0, 0, 1, FE, FACK, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(6'h3F, 0, 0, 0, DE, PCW, 1, 0, 0, 0, 0, 0));
    // fetch watchdog: 4 unacked cycles, idle cycle, retry
    vq.push_back(v(6'h3F, 0, 0, 0, FE, FREQ, 0, 0, 0, 0, 1, 0));
    vq.push_back(v(6'h3F, 0, 0, 0, FE, FREQ, 0, 0, 0, 0, 1, 0));
    vq.push_back(v(6'h3F, 0, 0, 0, FE, FREQ, 0, 0, 0, 0, 1, 0));
    vq.push_back(v(6'h3F, 0, 0, 0, FE, FREQ, 0, 0, 0, 0, 1, 0));
    vq.push_back(v(6'h3F, 0, 0, 1, FE, NONE, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(6'h2B, 0, 0, 1, FE, FACK, 0, 0, 0, 0, 1, 1));
    // sw with MEMWR watchdog abort
    vq.push_back(v(6'h2B, 0, 0, 0, DE, NONE, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(6'h2B, 0, 0, 0, EX, NONE, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(6'h2B, 0, 0, 0, MW, WRQ, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(6'h2B, 0, 0, 0, MW, WRQ, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(6'h2B, 0, 0, 0, MW, WRQ, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(6'h2B, 0, 0, 0, MW, WRAB, 1, 0, 0, 0, 1, 1));
    vq.push_back(v(6'h2B, 0, 0, 0, FE, NONE, 0, 0, 0, 0, 1, 1));
    // addi (I-type writes rt)
    vq.push_back(v(6'h08, 0, 0, 1, FE, FACK, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(6'h08, 0, 0, 0, DE, NONE, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(6'h08, 0, 0, 0, EX, NONE, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(6'h08, 0, 0, 0, WB, WRB, 1, 0, 1, 0, 1, 1));
    // jr
    vq.push_back(v(0, 6'h08, 0, 1, FE, FACK, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(0, 6'h08, 0, 0, DE, NONE, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(0, 6'h08, 0, 0, JP, PCW, 1, 3, 0, 0, 1, 1));

    repeat (2) @(negedge clk);
    #1;
    check(v(0, 0, 0, 0, RS, NONE, 0, 0, 0, 0, 0, 0), -1);
    @(negedge clk);
    rstn = 1'b1;
    foreach (vq[i]) begin
      apply(vq[i], i);
      @(negedge clk);
    end

    // reset pulsed mid-MEMWR
    apply(v(6'h2B, 0, 0, 1, FE, FACK, 0, 0, 0, 0, 1, 1), 100);
    @(negedge clk);
    apply(v(6'h2B, 0, 0, 0, DE, NONE, 0, 0, 0, 0, 1, 1), 101);
    @(negedge clk);
    apply(v(6'h2B, 0, 0, 0, EX, NONE, 0, 0, 0, 0, 1, 1), 102);
    @(negedge clk);
    apply(v(6'h2B, 0, 0, 0, MW, WRQ, 0, 0, 0, 0, 1, 1), 103);
    #1 rstn = 1'b0;
    apply(v(6'h2B, 0, 0, 1, RS, NONE, 0, 0, 0, 0, 0, 0), 104);
    @(negedge clk);
    rstn = 1'b1;
    apply(v(6'h2B, 0, 0, 0, RS, NONE, 0, 0, 0, 0, 0, 0), 105);
    @(negedge clk);
    apply(v(6'h2B, 0, 0, 0, FE, FREQ, 0, 0, 0, 0, 0, 0), 106);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
